eth_hdr_strip: RTL and testbench

- Receive-side Ethernet front end. It sits directly downstream of the testbench's Ethernet stimulus stream (64-bit DATA/KEEP/LAST/VALID/READY).
- Checks destination MAC against the FPGA address, strips the 14-byte Ethernet II header, and realigns the payload to lane 0 for the JSON packet parser.
- Emits source MAC/ethertype as sideband metadata; counts passed and dropped frames.

---
 rtl/eth_hdr_strip_if.sv | 19 +
 rtl/eth_hdr_strip.sv | 250 +++++++++++++++++++++++++
 tb/tb_eth_hdr_strip.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_hdr_strip_if.sv
// ============================================================================
// Module : eth_hdr_strip_if
// Brief  : 64-bit byte-lane stream bundle (DATA/KEEP/LAST/VALID/READY).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface eth_hdr_strip_if;
    logic [63:0] DATA;
    logic [7:0]  KEEP;
    logic        LAST;
    logic        VALID;
    logic        READY;

    modport master (output DATA, output KEEP, output LAST, output VALID, input  READY);
    modport slave  (input  DATA, input  KEEP, input  LAST, input  VALID, output READY);
endinterface

`default_nettype wire

// File: rtl/eth_hdr_strip.sv
// ============================================================================
// Module : eth_hdr_strip
// Brief  : Ethernet II receive front end: dst MAC filter, 14-byte header strip,
//          payload realignment to lane 0, src/ethertype sideband, frame counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module eth_hdr_strip #(
    parameter logic [47:0] MAC_ADDR = 48'hfa163e55ca02,
    parameter bit          BCAST_EN = 1'b1
) (
    input  wire logic         aclk,
    input  wire logic         aresetn,
    eth_hdr_strip_if.slave    stream_in,
    eth_hdr_strip_if.master   stream_out,
    output logic [47:0]       meta_src_mac,
    output logic [15:0]       meta_ethertype,
    output logic              meta_VALID,
    output logic [31:0]       frames_passed,
    output logic [31:0]       frames_dropped
);

    typedef enum logic [2:0] {
        ST_HDR0  = 3'd0,
        ST_HDR1  = 3'd1,
        ST_PASS  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DROP  = 3'd4
    } state_t;

    state_t      r_state;
    logic [15:0] r_src_lo;
    logic [15:0] r_h;
    logic        r_resid2;
    logic [63:0] r_out_data;
    logic [7:0]  r_out_keep;
    logic        r_out_last;
    logic        r_out_valid;
    logic [47:0] r_meta_src;
    logic [15:0] r_meta_et;
    logic        r_meta_valid;
    logic [31:0] r_passed;
    logic [31:0] r_dropped;

    logic        w_out_free;
    logic        w_in_ready;
    logic        w_fire;
    logic [7:0]  w_keep;
    logic [3:0]  w_n;
    logic        w_dst_ok;
    logic        w_bcast;
    logic        w_match;
    logic [8:0]  w_pass_keep;
    logic        w_emit;
    logic [63:0] w_emit_raw;
    logic [7:0]  w_emit_keep;
    logic        w_emit_last;
    logic        w_cnt_pass;
    logic        w_cnt_drop;

    function automatic logic [63:0] lane_mask(input logic [7:0] keep);
        lane_mask = '0;
        for (int i = 0; i < 8; i++) begin
            lane_mask[8*i +: 8] = {8{keep[i]}};
        end
    endfunction

    assign w_out_free = !r_out_valid || stream_out.READY;

    always_comb begin
        w_in_ready = w_out_free;
        case (r_state)
            ST_DROP:  w_in_ready = 1'b1;
            ST_FLUSH: w_in_ready = 1'b0;
            default:  w_in_ready = w_out_free;
        endcase
    end

    assign w_fire = stream_in.VALID && w_in_ready;

    // KEEP is only honoured on the final flit; earlier flits are full width.
    always_comb begin
        w_keep = stream_in.LAST ? stream_in.KEEP : 8'hff;
        w_n    = '0;
        for (int i = 0; i < 8; i++) begin
            w_n = w_n + {3'b000, w_keep[i]};
        end
    end

    always_comb begin
        w_dst_ok = 1'b1;
        w_bcast  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (stream_in.DATA[8*k +: 8] != MAC_ADDR[47-8*k -: 8]) w_dst_ok = 1'b0;
            if (stream_in.DATA[8*k +: 8] != 8'hff)                 w_bcast  = 1'b0;
        end
        w_match = w_dst_ok || (BCAST_EN && w_bcast);
    end

    assign w_pass_keep = (9'd1 << (w_n + 4'd2)) - 9'd1;

    // Next output flit and counter strobes, decided from the current state.
    always_comb begin
        w_emit      = 1'b0;
        w_emit_raw  = '0;
        w_emit_keep = '0;
        w_emit_last = 1'b0;
        w_cnt_pass  = 1'b0;
        w_cnt_drop  = 1'b0;
        case (r_state)
            ST_HDR0: begin
                if (w_fire && stream_in.LAST) w_cnt_drop = 1'b1;
            end
            ST_HDR1: begin
                if (w_fire && stream_in.LAST) begin
                    if (w_n <= 4'd6) begin
                        w_cnt_drop = 1'b1;
                    end else begin
                        w_emit      = 1'b1;
                        w_emit_raw  = {48'h0, stream_in.DATA[63:48]};
                        w_emit_keep = (w_n == 4'd8) ? 8'h03 : 8'h01;
                        w_emit_last = 1'b1;
                        w_cnt_pass  = 1'b1;
                    end
                end
            end
            ST_PASS: begin
                if (w_fire) begin
                    w_emit      = 1'b1;
                    w_emit_raw  = {stream_in.DATA[47:0], r_h};
                    w_emit_keep = 8'hff;
                    if (stream_in.LAST && (w_n <= 4'd6)) begin
                        w_emit_keep = w_pass_keep[7:0];
                        w_emit_last = 1'b1;
                        w_cnt_pass  = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (w_out_free) begin
                    w_emit      = 1'b1;
                    w_emit_raw  = {48'h0, r_h};
                    w_emit_keep = r_resid2 ? 8'h03 : 8'h01;
                    w_emit_last = 1'b1;
                    w_cnt_pass  = 1'b1;
                end
            end
            ST_DROP: begin
                if (w_fire && stream_in.LAST) w_cnt_drop = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= ST_HDR0;
            r_src_lo     <= '0;
            r_h          <= '0;
            r_resid2     <= 1'b0;
            r_out_data   <= '0;
            r_out_keep   <= '0;
            r_out_last   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_meta_src   <= '0;
            r_meta_et    <= '0;
            r_meta_valid <= 1'b0;
            r_passed     <= '0;
            r_dropped    <= '0;
        end else begin
            r_meta_valid <= 1'b0;

            if (w_emit) begin
                // Lanes beyond KEEP are forced to zero.
                r_out_data  <= w_emit_raw & lane_mask(w_emit_keep);
                r_out_keep  <= w_emit_keep;
                r_out_last  <= w_emit_last;
                r_out_valid <= 1'b1;
            end else if (stream_out.READY) begin
                r_out_valid <= 1'b0;
            end

            if (w_cnt_pass) r_passed  <= r_passed + 32'd1;
            if (w_cnt_drop) r_dropped <= r_dropped + 32'd1;

            case (r_state)
                ST_HDR0: begin
                    if (w_fire && !stream_in.LAST) begin
                        if (w_match) begin
                            r_src_lo <= stream_in.DATA[63:48];
                            r_state  <= ST_HDR1;
                        end else begin
                            r_state  <= ST_DROP;
                        end
                    end
                end
                ST_HDR1: begin
                    if (w_fire) begin
                        if (stream_in.LAST && (w_n <= 4'd6)) begin
                            r_state <= ST_HDR0;
                        end else begin
                            r_meta_src   <= {r_src_lo[7:0], r_src_lo[15:8],
                                             stream_in.DATA[7:0],   stream_in.DATA[15:8],
                                             stream_in.DATA[23:16], stream_in.DATA[31:24]};
                            r_meta_et    <= {stream_in.DATA[39:32], stream_in.DATA[47:40]};
                            r_meta_valid <= 1'b1;
                            r_h          <= stream_in.DATA[63:48];
                            r_state      <= stream_in.LAST ? ST_HDR0 : ST_PASS;
                        end
                    end
                end
                ST_PASS: begin
                    if (w_fire) begin
                        r_h <= stream_in.DATA[63:48];
                        if (stream_in.LAST) begin
                            if (w_n <= 4'd6) begin
                                r_state <= ST_HDR0;
                            end else begin
                                r_resid2 <= (w_n == 4'd8);
                                r_state  <= ST_FLUSH;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_out_free) r_state <= ST_HDR0;
                end
                ST_DROP: begin
                    if (w_fire && stream_in.LAST) r_state <= ST_HDR0;
                end
                default: r_state <= ST_HDR0;
            endcase
        end
    end

    assign stream_in.READY   = w_in_ready;
    assign stream_out.DATA   = r_out_data;
    assign stream_out.KEEP   = r_out_keep;
    assign stream_out.LAST   = r_out_last;
    assign stream_out.VALID  = r_out_valid;
    assign meta_src_mac      = r_meta_src;
    assign meta_ethertype    = r_meta_et;
    assign meta_VALID        = r_meta_valid;
    assign frames_passed     = r_passed;
    assign frames_dropped    = r_dropped;

endmodule

`default_nettype wire

// File: tb/tb_eth_hdr_strip.sv
// ============================================================================
// Module : tb_eth_hdr_strip
// Brief  : Randomised self-checking bench for eth_hdr_strip with a byte-level
//          frame reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_eth_hdr_strip;

    localparam logic [47:0] C_MAC = 48'hfa163e55ca02;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } flit_t;

    logic aclk;
    logic aresetn;

    eth_hdr_strip_if in_a();
    eth_hdr_strip_if out_a();
    eth_hdr_strip_if in_b();
    eth_hdr_strip_if out_b();

    logic [47:0] ma_src, mb_src;
    logic [15:0] ma_et, mb_et;
    logic        ma_v, mb_v;
    logic [31:0] pa, da, pb, db;

    eth_hdr_strip #(.MAC_ADDR(C_MAC), .BCAST_EN(1'b1)) dut_a (
        .aclk(aclk), .aresetn(aresetn), .stream_in(in_a), .stream_out(out_a),
        .meta_src_mac(ma_src), .meta_ethertype(ma_et), .meta_VALID(ma_v),
        .frames_passed(pa), .frames_dropped(da));

    eth_hdr_strip #(.MAC_ADDR(C_MAC), .BCAST_EN(1'b0)) dut_b (
        .aclk(aclk), .aresetn(aresetn), .stream_in(in_b), .stream_out(out_b),
        .meta_src_mac(mb_src), .meta_ethertype(mb_et), .meta_VALID(mb_v),
        .frames_passed(pb), .frames_dropped(db));

    int          n_tests = 0;
    int          n_fail  = 0;
    flit_t       q_out[$];
    logic [63:0] q_meta[$];
    logic [7:0]  g_frame[$];
    int          exp_passed = 0;
    int          exp_dropped = 0;
    bit          bp_en = 1'b0;
    int          hold_cnt = 0;
    int          b_out_cnt = 0;
    bit          held = 1'b0;
    flit_t       h_flit;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bytes 6..11 are the source MAC, 12..13 the ethertype.
    function automatic logic [63:0] meta_of();
        return {g_frame[6], g_frame[7], g_frame[8], g_frame[9],
                g_frame[10], g_frame[11], g_frame[12], g_frame[13]};
    endfunction

    function automatic bit frame_passes();
        logic [47:0] mac;
        bit          mt, bc;
        mac = C_MAC;
        if (g_frame.size() <= 14) return 1'b0;
        mt = 1'b1;
        bc = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (g_frame[k] != mac[47-8*k -: 8]) mt = 1'b0;
            if (g_frame[k] != 8'hff)            bc = 1'b0;
        end
        return mt || bc;
    endfunction

    task automatic model_frame();
        flit_t f;
        int    len;
        len = g_frame.size();
        if (!frame_passes()) begin
            exp_dropped++;
        end else begin
            exp_passed++;
            q_meta.push_back(meta_of());
            for (int p = 14; p < len; p += 8) begin
                f = '0;
                for (int j = 0; j < 8; j++) begin
                    if (p + j < len) begin
                        f.data[8*j +: 8] = g_frame[p+j];
                        f.keep[j]        = 1'b1;
                    end
                end
                f.last = (p + 8 >= len);
                q_out.push_back(f);
            end
        end
    endtask

    task automatic push_flit(input logic [63:0] d, input int nb);
        for (int j = 0; j < nb; j++) g_frame.push_back(d[8*j +: 8]);
    endtask

    task automatic build_s1();
        g_frame.delete();
        push_flit(64'hc40c02ca553e16fa, 8);
        push_flit(64'h0201b58847c0887a, 8);
        push_flit(64'h0a09080706050403, 8);
    endtask

    task automatic set_in(input bit to_b, input logic [63:0] d, input logic [7:0] k,
                          input logic l, input logic v);
        if (to_b) begin
            in_b.DATA = d; in_b.KEEP = k; in_b.LAST = l; in_b.VALID = v;
        end else begin
            in_a.DATA = d; in_a.KEEP = k; in_a.LAST = l; in_a.VALID = v;
        end
    endtask

    function automatic logic in_rdy(input bit to_b);
        return to_b ? in_b.READY : in_a.READY;
    endfunction

    task automatic drive_frame(input bit to_b, input int max_flits, input bit chk_ready);
        int          len, nf, guard;
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        len = g_frame.size();
        nf  = (len + 7) / 8;
        if (max_flits < nf) nf = max_flits;
        for (int i = 0; i < nf; i++) begin
            d = {$urandom, $urandom};
            k = 8'($urandom);
            l = (8*i + 8 >= len);
            for (int j = 0; j < 8; j++) begin
                if (8*i + j < len) d[8*j +: 8] = g_frame[8*i+j];
                if (l) k[j] = (8*i + j < len);
            end
            if (!to_b && ($urandom % 4 == 0)) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge aclk);
                    set_in(to_b, '0, '0, 1'b0, 1'b0);
                end
            end
            @(negedge aclk);
            set_in(to_b, d, k, l, 1'b1);
            #2;
            if (chk_ready) check("drop_in_ready", in_rdy(to_b), 1);
            guard = 0;
            while (!in_rdy(to_b) && guard < 500) begin
                @(negedge aclk);
                #2;
                guard++;
            end
            if (guard >= 500) check("in_ready_wait", in_rdy(to_b), 1);
            @(posedge aclk);
        end
        @(negedge aclk);
        set_in(to_b, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((q_out.size() != 0 || q_meta.size() != 0) && guard < 2000) begin
            @(negedge aclk);
            guard++;
        end
        repeat (3) @(negedge aclk);
        check("drain", 64'(q_out.size() + q_meta.size()), 0);
        check("frames_passed", pa, 64'(exp_passed));
        check("frames_dropped", da, 64'(exp_dropped));
    endtask

    initial begin
        out_a.READY = 1'b1;
        out_b.READY = 1'b1;
        forever begin
            @(negedge aclk);
            if (hold_cnt > 0) begin
                out_a.READY = 1'b0;
                hold_cnt--;
            end else begin
                out_a.READY = bp_en ? ($urandom % 3 != 0) : 1'b1;
            end
        end
    end

    // Output / metadata monitor, sampled mid-cycle.
    initial begin
        flit_t f;
        forever begin
            @(negedge aclk);
            #3;
            if (!aresetn) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", out_a.VALID, 1);
                    check("hold_flit", {out_a.DATA, out_a.KEEP, out_a.LAST},
                          {h_flit.data, h_flit.keep, h_flit.last});
                end
                if (out_a.VALID && out_a.READY) begin
                    check("out_pending", q_out.size() != 0, 1);
                    if (q_out.size() != 0) begin
                        f = q_out.pop_front();
                        check("out_data", out_a.DATA, f.data);
                        check("out_keep_last", {out_a.KEEP, out_a.LAST}, {f.keep, f.last});
                    end
                end
                held        = out_a.VALID && !out_a.READY;
                h_flit.data = out_a.DATA;
                h_flit.keep = out_a.KEEP;
                h_flit.last = out_a.LAST;
                if (ma_v) begin
                    check("meta_pending", q_meta.size() != 0, 1);
                    if (q_meta.size() != 0) check("meta", {ma_src, ma_et}, q_meta.pop_front());
                end
                if (out_b.VALID) b_out_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          len, sel;
        logic [47:0] mac;
        mac     = C_MAC;
        aresetn = 1'b0;
        set_in(1'b0, '0, '0, 1'b0, 1'b0);
        set_in(1'b1, '0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge aclk);
        #3;
        check("rst_out", {out_a.VALID, out_a.DATA, out_a.KEEP, out_a.LAST}, 0);
        check("rst_meta", {ma_v, ma_src, ma_et}, 0);
        check("rst_cnt", {pa, da}, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        #3;
        check("rst_in_ready", in_a.READY, 1);

        // Pass + flush
        build_s1(); model_frame(); drive_frame(1'b0, 99, 1'b0); wait_drain();
        check("s1_src", ma_src, 48'h0cc47a88c047);
        check("s1_et", ma_et, 16'h88b5);

        // MAC mismatch: input must never stall
        build_s1(); g_frame[0] = 8'hfb; model_frame(); drive_frame(1'b0, 99, 1'b1); wait_drain();

        // Broadcast
        build_s1(); for (int k = 0; k < 6; k++) g_frame[k] = 8'hff;
        model_frame(); drive_frame(1'b0, 99, 1'b0); wait_drain();

        // Runts and minimal frames
        build_s1(); while (g_frame.size() > 14) void'(g_frame.pop_back());
        model_frame(); drive_frame(1'b0, 99, 1'b0); wait_drain();
        build_s1(); while (g_frame.size() > 5) void'(g_frame.pop_back());
        model_frame(); drive_frame(1'b0, 99, 1'b0); wait_drain();
        build_s1(); while (g_frame.size() > 16) void'(g_frame.pop_back());
        model_frame(); drive_frame(1'b0, 99, 1'b0); wait_drain();
        build_s1(); while (g_frame.size() > 15) void'(g_frame.pop_back());
        model_frame(); drive_frame(1'b0, 99, 1'b0); wait_drain();

        // Backpressure: 30-byte payload with a 5-cycle stall mid-frame
        build_s1(); while (g_frame.size() > 14) void'(g_frame.pop_back());
        for (int i = 0; i < 30; i++) g_frame.push_back(8'(i + 8'h40));
        model_frame();
        fork
            drive_frame(1'b0, 99, 1'b0);
            begin
                repeat (4) @(negedge aclk);
                #1 hold_cnt = 5;
                repeat (5) begin
                    @(negedge aclk);
                    #3;
                    if (out_a.VALID) check("bp_in_ready", in_a.READY, 0);
                end
            end
        join
        wait_drain();

        // Reset in the middle of a frame
        build_s1();
        q_meta.push_back(meta_of());
        drive_frame(1'b0, 2, 1'b0);
        repeat (3) @(negedge aclk);
        check("pre_rst_meta", 64'(q_meta.size()), 0);
        #1 aresetn = 1'b0;
        #2;
        check("mid_rst_out", {out_a.VALID, out_a.DATA, out_a.KEEP, out_a.LAST}, 0);
        check("mid_rst_meta", {ma_v, ma_src, ma_et}, 0);
        check("mid_rst_cnt", {pa, da}, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        q_out.delete(); q_meta.delete();
        exp_passed = 0; exp_dropped = 0;
        build_s1(); model_frame(); drive_frame(1'b0, 99, 1'b0); wait_drain();
        check("rst_s1_src", ma_src, 48'h0cc47a88c047);

        // Broadcast rejected when BCAST_EN=0
        b_out_cnt = 0;
        build_s1(); for (int k = 0; k < 6; k++) g_frame[k] = 8'hff;
        drive_frame(1'b1, 99, 1'b0);
        repeat (6) @(negedge aclk);
        check("b_bcast_dropped", db, 1);
        check("b_bcast_passed", pb, 0);
        check("b_bcast_out", 64'(b_out_cnt), 0);
        build_s1(); drive_frame(1'b1, 99, 1'b0);
        repeat (6) @(negedge aclk);
        check("b_uni_passed", pb, 1);
        check("b_uni_out", 64'(b_out_cnt), 2);

        // Random frames
        for (int fr = 0; fr < 60; fr++) begin
            bp_en = (fr % 2 == 1);
            g_frame.delete();
            len = $urandom_range(1, 64);
            sel = $urandom % 8;
            for (int i = 0; i < len; i++) g_frame.push_back(8'($urandom));
            for (int k = 0; k < 6 && k < len; k++) begin
                if (sel < 5)       g_frame[k] = mac[47-8*k -: 8];
                else if (sel < 6)  g_frame[k] = 8'hff;
            end
            if (sel >= 6) g_frame[0] = mac[47:40] ^ 8'h01;
            model_frame();
            drive_frame(1'b0, 99, 1'b0);
            wait_drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
